// File: rtl/pipe_ctrl_if.sv
// Stage-to-controller bundle for the pipeline hazard/sequencing controller.
// The slave modport is the controller's view; master is the pipeline's view.
interface pipe_ctrl_if #(
  parameter int XLEN          = 64,
  parameter int REG_ADDRWIDTH = 5
);
  logic [REG_ADDRWIDTH-1:0] id_rs1_idx_i;
  logic [REG_ADDRWIDTH-1:0] id_rs2_idx_i;
  logic                     id_rs1_ren_i;
  logic                     id_rs2_ren_i;
  logic [REG_ADDRWIDTH-1:0] ex_rd_idx_i;
  logic                     ex_rd_wen_i;
  logic                     ex_is_load_i;
  logic                     ifu_busy_i;
  logic                     alu_busy_i;
  logic                     lsu_busy_i;
  logic                     bru_redirect_i;
  logic [XLEN-1:0]          bru_target_i;
  logic                     trap_req_i;
  logic [XLEN-1:0]          trap_vec_i;
  logic                     ebreak_i;
  logic [4:0]               stall_o;
  logic [4:0]               flush_o;
  logic                     redirect_valid_o;
  logic [XLEN-1:0]          redirect_pc_o;
  logic                     halt_o;
  logic [31:0]              stall_cycles_o;

  modport slave (
    input  id_rs1_idx_i, id_rs2_idx_i, id_rs1_ren_i, id_rs2_ren_i,
    input  ex_rd_idx_i, ex_rd_wen_i, ex_is_load_i,
    input  ifu_busy_i, alu_busy_i, lsu_busy_i,
    input  bru_redirect_i, bru_target_i, trap_req_i, trap_vec_i, ebreak_i,
    output stall_o, flush_o, redirect_valid_o, redirect_pc_o, halt_o, stall_cycles_o
  );

  modport master (
    output id_rs1_idx_i, id_rs2_idx_i, id_rs1_ren_i, id_rs2_ren_i,
    output ex_rd_idx_i, ex_rd_wen_i, ex_is_load_i,
    output ifu_busy_i, alu_busy_i, lsu_busy_i,
    output bru_redirect_i, bru_target_i, trap_req_i, trap_vec_i, ebreak_i,
    input  stall_o, flush_o, redirect_valid_o, redirect_pc_o, halt_o, stall_cycles_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Hazard and sequencing controller for the five-stage core: per-stage stall/flush,
// PC redirect select, trap drain FSM and a saturating stall-cycle counter.
//
// state   | meaning
// RUN     | normal issue; prioritised hazard resolution
// DRAIN   | trap taken while a memory access is outstanding; wait for LSU idle
// HALT    | ebreak committed; pipeline frozen until reset
module pipe_ctrl #(
  parameter int XLEN = 64
) (
  input logic       clk,
  input logic       rst,
  pipe_ctrl_if.slave bus
);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALT} state_t;

  state_t          state_q, state_d;
  logic            rst_q;
  logic [XLEN-1:0] trap_vec_q, trap_vec_d;
  logic [31:0]     stall_cnt_q;
  logic [4:0]      stall, flush;
  logic            redir_valid, halt;
  logic [XLEN-1:0] redir_pc;
  logic            load_use;

  // Reset asserts asynchronously but releases on the first clk edge after rst rises.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_q <= 1'b0;
    else      rst_q <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_RUN;
      trap_vec_q  <= '0;
      stall_cnt_q <= '0;
    end else if (rst_q) begin
      state_q    <= state_d;
      trap_vec_q <= trap_vec_d;
      if (stall[0] && state_q != S_HALT && stall_cnt_q != 32'hFFFF_FFFF)
        stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign load_use = bus.ex_is_load_i && bus.ex_rd_wen_i && (bus.ex_rd_idx_i != '0) &&
                    ((bus.id_rs1_ren_i && bus.id_rs1_idx_i == bus.ex_rd_idx_i) ||
                     (bus.id_rs2_ren_i && bus.id_rs2_idx_i == bus.ex_rd_idx_i));

  always_comb begin
    state_d     = state_q;
    trap_vec_d  = trap_vec_q;
    stall       = 5'b00000;
    flush       = 5'b00000;
    redir_valid = 1'b0;
    redir_pc    = '0;
    halt        = 1'b0;
    if (rst_q) begin
      unique case (state_q)
        S_RUN: begin
          if (bus.ebreak_i) begin
            stall   = 5'b11111;
            state_d = S_HALT;
          end else if (bus.trap_req_i && !bus.lsu_busy_i) begin
            flush       = 5'b11110;
            redir_valid = 1'b1;
            redir_pc    = bus.trap_vec_i;
          end else if (bus.trap_req_i) begin
            stall      = 5'b01111;
            flush      = 5'b10000;
            trap_vec_d = bus.trap_vec_i;
            state_d    = S_DRAIN;
          end else if (bus.lsu_busy_i) begin
            stall = 5'b01111;
            flush = 5'b10000;
          end else if (bus.alu_busy_i) begin
            stall = 5'b00111;
            flush = 5'b01000;
          end else if (load_use) begin
            stall = 5'b00011;
            flush = 5'b00100;
          end else if (bus.bru_redirect_i) begin
            // Redirect outranks a fetch miss; the IFU drops the miss on redirect.
            flush       = 5'b00110;
            redir_valid = 1'b1;
            redir_pc    = bus.bru_target_i;
          end else if (bus.ifu_busy_i) begin
            stall = 5'b00001;
            flush = 5'b00010;
          end
        end
        S_DRAIN: begin
          if (bus.lsu_busy_i) begin
            stall = 5'b01111;
            flush = 5'b10000;
          end else begin
            flush       = 5'b11110;
            redir_valid = 1'b1;
            redir_pc    = trap_vec_q;
            state_d     = S_RUN;
          end
        end
        S_HALT: begin
          stall = 5'b11111;
          halt  = 1'b1;
        end
        default: state_d = S_RUN;
      endcase
    end
  end

  assign bus.stall_o          = stall;
  assign bus.flush_o          = flush;
  assign bus.redirect_valid_o = redir_valid;
  assign bus.redirect_pc_o    = redir_pc;
  assign bus.halt_o           = halt;
  assign bus.stall_cycles_o   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl: hazard priorities, trap drain,
// halt, async reset and stall counter saturation.
module tb_pipe_ctrl;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [31:0] exp_cnt;
  logic [75:0] obs;

  pipe_ctrl_if #(.XLEN(64), .REG_ADDRWIDTH(5)) bus ();

  pipe_ctrl #(.XLEN(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // {stall, flush, redirect_valid, halt, redirect_pc}
  assign obs = {bus.stall_o, bus.flush_o, bus.redirect_valid_o, bus.halt_o, bus.redirect_pc_o};

  task automatic clr_inputs();
    bus.id_rs1_idx_i   = '0;
    bus.id_rs2_idx_i   = '0;
    bus.id_rs1_ren_i   = 1'b0;
    bus.id_rs2_ren_i   = 1'b0;
    bus.ex_rd_idx_i    = '0;
    bus.ex_rd_wen_i    = 1'b0;
    bus.ex_is_load_i   = 1'b0;
    bus.ifu_busy_i     = 1'b0;
    bus.alu_busy_i     = 1'b0;
    bus.lsu_busy_i     = 1'b0;
    bus.bru_redirect_i = 1'b0;
    bus.bru_target_i   = '0;
    bus.trap_req_i     = 1'b0;
    bus.trap_vec_i     = '0;
    bus.ebreak_i       = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.ebreak_i = 1'b1; bus.lsu_busy_i = 1'b1; bus.trap_req_i = 1'b1;
    bus.bru_redirect_i = 1'b1; bus.bru_target_i = 64'h1234;
    tick(); #1;
    checks++;
    if (obs !== 76'd0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", obs);
    end
    checks++;
    if (bus.stall_cycles_o !== 32'd0) begin
      errors++; $display("FAIL reset_counter: got %h expected 0", bus.stall_cycles_o);
    end
    clr_inputs();
    rst = 1'b1;
    bus.lsu_busy_i = 1'b1;
    #1;
    checks++;
    if (obs !== 76'd0) begin
      errors++; $display("FAIL reset_release_pending: got %h expected 0", obs);
    end
    @(posedge clk); #1;
    checks++;
    if (obs !== {5'b01111, 5'b10000, 1'b0, 1'b0, 64'd0}) begin
      errors++; $display("FAIL reset_released_lsu: got %h", obs);
    end
    @(negedge clk);
    clr_inputs(); #1;
    checks++;
    if (bus.stall_cycles_o !== 32'd0) begin
      errors++; $display("FAIL reset_release_cnt: got %h expected 0", bus.stall_cycles_o);
    end
  endtask

  task automatic test_load_use();
    bus.ex_is_load_i = 1'b1; bus.ex_rd_wen_i = 1'b1; bus.ex_rd_idx_i = 5'd5;
    bus.id_rs2_idx_i = 5'd5; bus.id_rs2_ren_i = 1'b1;
    bus.id_rs1_idx_i = 5'd3; bus.id_rs1_ren_i = 1'b1;
    #1;
    checks++;
    if (obs !== {5'b00011, 5'b00100, 1'b0, 1'b0, 64'd0}) begin
      errors++; $display("FAIL load_use_x5: got %h", obs);
    end
    tick(); exp_cnt++;
    bus.ex_is_load_i = 1'b0; #1;
    checks++;
    if (obs !== 76'd0) begin
      errors++; $display("FAIL load_use_one_bubble: got %h expected 0", obs);
    end
    bus.ex_is_load_i = 1'b1; bus.ex_rd_idx_i = 5'd0; bus.id_rs2_idx_i = 5'd0; #1;
    checks++;
    if (obs !== 76'd0) begin
      errors++; $display("FAIL load_use_x0: got %h expected 0", obs);
    end
    bus.ex_rd_idx_i = 5'd7; bus.id_rs1_idx_i = 5'd7; bus.id_rs1_ren_i = 1'b0;
    bus.id_rs2_idx_i = 5'd1; #1;
    checks++;
    if (obs !== 76'd0) begin
      errors++; $display("FAIL load_use_ren0: got %h expected 0", obs);
    end
    bus.id_rs1_ren_i = 1'b1; #1;
    checks++;
    if (obs !== {5'b00011, 5'b00100, 1'b0, 1'b0, 64'd0}) begin
      errors++; $display("FAIL load_use_rs1: got %h", obs);
    end
    clr_inputs(); #1;
    checks++;
    if (bus.stall_cycles_o !== exp_cnt) begin
      errors++; $display("FAIL load_use_cnt: got %0d expected %0d", bus.stall_cycles_o, exp_cnt);
    end
  endtask

  task automatic test_redirect();
    bus.bru_redirect_i = 1'b1; bus.bru_target_i = 64'h8000_0040; bus.ifu_busy_i = 1'b1; #1;
    checks++;
    if (obs !== {5'b00000, 5'b00110, 1'b1, 1'b0, 64'h8000_0040}) begin
      errors++; $display("FAIL redirect_over_ifu: got %h", obs);
    end
    tick();
    bus.bru_redirect_i = 1'b0; #1;
    checks++;
    if (obs !== {5'b00001, 5'b00010, 1'b0, 1'b0, 64'd0}) begin
      errors++; $display("FAIL ifu_busy: got %h", obs);
    end
    tick(); exp_cnt++;
    clr_inputs();
    bus.alu_busy_i = 1'b1; bus.ifu_busy_i = 1'b1;
    bus.ex_is_load_i = 1'b1; bus.ex_rd_wen_i = 1'b1; bus.ex_rd_idx_i = 5'd9;
    bus.id_rs1_idx_i = 5'd9; bus.id_rs1_ren_i = 1'b1; #1;
    checks++;
    if (obs !== {5'b00111, 5'b01000, 1'b0, 1'b0, 64'd0}) begin
      errors++; $display("FAIL alu_over_load_use: got %h", obs);
    end
    tick(); exp_cnt++;
    clr_inputs();
  endtask

  task automatic test_deferred_redirect();
    bus.bru_redirect_i = 1'b1; bus.bru_target_i = 64'h8000_0040; bus.lsu_busy_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (obs !== {5'b01111, 5'b10000, 1'b0, 1'b0, 64'd0}) begin
        errors++; $display("FAIL deferred_stall_%0d: got %h", i, obs);
      end
      tick(); exp_cnt++;
    end
    bus.lsu_busy_i = 1'b0; #1;
    checks++;
    if (obs !== {5'b00000, 5'b00110, 1'b1, 1'b0, 64'h8000_0040}) begin
      errors++; $display("FAIL deferred_fire: got %h", obs);
    end
    checks++;
    if (bus.stall_cycles_o !== exp_cnt) begin
      errors++; $display("FAIL deferred_cnt: got %0d expected %0d", bus.stall_cycles_o, exp_cnt);
    end
    tick();
    clr_inputs();
  endtask

  task automatic test_trap();
    bus.trap_req_i = 1'b1; bus.trap_vec_i = 64'h8000_0200; #1;
    checks++;
    if (obs !== {5'b00000, 5'b11110, 1'b1, 1'b0, 64'h8000_0200}) begin
      errors++; $display("FAIL trap_immediate: got %h", obs);
    end
    tick();
    bus.trap_vec_i = 64'h8000_0100; bus.lsu_busy_i = 1'b1; #1;
    checks++;
    if (obs !== {5'b01111, 5'b10000, 1'b0, 1'b0, 64'd0}) begin
      errors++; $display("FAIL trap_enter_drain: got %h", obs);
    end
    tick(); exp_cnt++;
    bus.trap_req_i = 1'b0; bus.trap_vec_i = 64'd0; bus.ebreak_i = 1'b1;
    bus.bru_redirect_i = 1'b1; bus.bru_target_i = 64'hDEAD; #1;
    checks++;
    if (obs !== {5'b01111, 5'b10000, 1'b0, 1'b0, 64'd0}) begin
      errors++; $display("FAIL trap_drain_hold: got %h", obs);
    end
    tick(); exp_cnt++;
    bus.lsu_busy_i = 1'b0; #1;
    checks++;
    if (obs !== {5'b00000, 5'b11110, 1'b1, 1'b0, 64'h8000_0100}) begin
      errors++; $display("FAIL trap_drain_exit: got %h", obs);
    end
    tick();
    clr_inputs(); #1;
    checks++;
    if (obs !== 76'd0) begin
      errors++; $display("FAIL trap_back_to_run: got %h expected 0", obs);
    end
    checks++;
    if (bus.stall_cycles_o !== exp_cnt) begin
      errors++; $display("FAIL trap_cnt: got %0d expected %0d", bus.stall_cycles_o, exp_cnt);
    end
  endtask

  task automatic test_halt();
    bus.ebreak_i = 1'b1; #1;
    checks++;
    if (obs !== {5'b11111, 5'b00000, 1'b0, 1'b0, 64'd0}) begin
      errors++; $display("FAIL halt_ebreak: got %h", obs);
    end
    tick(); exp_cnt++;
    bus.ebreak_i = 1'b0; bus.lsu_busy_i = 1'b1; bus.bru_redirect_i = 1'b1;
    bus.bru_target_i = 64'h40; bus.trap_req_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (obs !== {5'b11111, 5'b00000, 1'b0, 1'b1, 64'd0}) begin
        errors++; $display("FAIL halt_hold_%0d: got %h", i, obs);
      end
      checks++;
      if (bus.stall_cycles_o !== exp_cnt) begin
        errors++; $display("FAIL halt_cnt_frozen_%0d: got %0d expected %0d", i, bus.stall_cycles_o, exp_cnt);
      end
      tick();
    end
    #2 rst = 1'b0; #1;
    checks++;
    if ({obs, bus.stall_cycles_o} !== 108'd0) begin
      errors++; $display("FAIL halt_async_reset: got %h", {obs, bus.stall_cycles_o});
    end
    exp_cnt = 32'd0;
    @(negedge clk);
    clr_inputs();
    rst = 1'b1;
    tick(); #1;
    checks++;
    if (obs !== 76'd0) begin
      errors++; $display("FAIL halt_reset_run: got %h expected 0", obs);
    end
  endtask

  task automatic test_saturation();
    force dut.stall_cnt_q = 32'hFFFF_FFFD;
    #1 release dut.stall_cnt_q;
    #1;
    checks++;
    if (bus.stall_cycles_o !== 32'hFFFF_FFFD) begin
      errors++; $display("FAIL sat_preload: got %h expected fffffffd", bus.stall_cycles_o);
    end
    bus.ifu_busy_i = 1'b1;
    tick(); #1;
    checks++;
    if (bus.stall_cycles_o !== 32'hFFFF_FFFE) begin
      errors++; $display("FAIL sat_step: got %h expected fffffffe", bus.stall_cycles_o);
    end
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      checks++;
      if (bus.stall_cycles_o !== 32'hFFFF_FFFF) begin
        errors++; $display("FAIL sat_hold_%0d: got %h expected ffffffff", i, bus.stall_cycles_o);
      end
    end
    clr_inputs();
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    exp_cnt = 32'd0;
    rst     = 1'b0;
    clr_inputs();
    @(negedge clk);
    test_reset();
    @(negedge clk);
    test_load_use();
    @(negedge clk);
    test_redirect();
    test_deferred_redirect();
    test_trap();
    test_halt();
    @(negedge clk);
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
